piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 21 ++
 rtl/piso_hold_reg.sv | 41 ++++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types for the parallel-in serial-out serializer.
// FSM state encoding and bit-order flag values.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  function automatic logic pick_order(
    input logic lsb_first,
    input logic msb_default
  );
    if (lsb_first) return ORDER_LSB;
    return msb_default ? ORDER_MSB : ORDER_LSB;
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-word holding register in front of the shifter.
// Captures word and bit order; freed when the shifter takes it.
module piso_hold_reg
  import piso_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter bit MSB_FIRST_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             lsb_first,
  input  logic             take,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_word,
  output logic             hold_order
);

  logic accept;

  assign in_ready = !hold_valid;
  assign accept   = in_valid && !hold_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
      hold_order <= ORDER_MSB;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_word  <= parallel_in;
      hold_order <= pick_order(lsb_first,
                               MSB_FIRST_DEFAULT);
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word skid holder.
// Back-to-back words stream without gaps when the holder is full.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH             = 8,
  parameter bit MSB_FIRST_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             lsb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             serial_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             cur_order;

  logic             hold_valid;
  logic [WIDTH-1:0] hold_word;
  logic             hold_order;
  logic             at_last;
  logic             consume;
  logic             take;

  piso_hold_reg #(
    .WIDTH            (WIDTH),
    .MSB_FIRST_DEFAULT(MSB_FIRST_DEFAULT)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .parallel_in(parallel_in),
    .lsb_first  (lsb_first),
    .take       (take),
    .hold_valid (hold_valid),
    .hold_word  (hold_word),
    .hold_order (hold_order)
  );

  assign at_last = (cnt == LAST);
  assign consume = (state == SHIFT) && shift_en;
  // Reload from the holder when idle or right as the last bit leaves
  assign take    = hold_valid &&
                   ((state == IDLE) || (consume && at_last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      cur_order <= ORDER_MSB;
    end else if (take) begin
      state     <= SHIFT;
      sreg      <= hold_word;
      cnt       <= '0;
      cur_order <= hold_order;
    end else if (consume) begin
      if (at_last) begin
        state <= IDLE;
        sreg  <= '0;
        cnt   <= '0;
      end else begin
        sreg <= (cur_order == ORDER_LSB) ? (sreg >> 1)
                                         : (sreg << 1);
        cnt  <= cnt + CW'(1);
      end
    end
  end

  assign serial_valid = (state == SHIFT);
  assign serial_last  = (state == SHIFT) && at_last;
  assign serial_out   = (state == SHIFT) &&
                        ((cur_order == ORDER_LSB) ? sreg[0]
                                                  : sreg[WIDTH-1]);
  assign busy         = (state == SHIFT) || hold_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer at WIDTH=4 and WIDTH=8.
// Inputs change and outputs are sampled on the falling edge.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       a_in_valid = 0, a_lsb = 0, a_sen = 1;
  logic [3:0] a_par = '0;
  logic       a_rdy, a_out, a_vld, a_last, a_busy;

  logic       b_in_valid = 0, b_lsb = 0, b_sen = 1;
  logic [7:0] b_par = '0;
  logic       b_rdy, b_out, b_vld, b_last, b_busy;

  piso_serializer #(.WIDTH(4), .MSB_FIRST_DEFAULT(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_rdy),
    .parallel_in(a_par), .lsb_first(a_lsb),
    .shift_en(a_sen), .serial_out(a_out),
    .serial_valid(a_vld), .serial_last(a_last),
    .busy(a_busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST_DEFAULT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_rdy),
    .parallel_in(b_par), .lsb_first(b_lsb),
    .shift_en(b_sen), .serial_out(b_out),
    .serial_valid(b_vld), .serial_last(b_last),
    .busy(b_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_a_vld"},  a_vld,  1'b0);
    chk({tag, "_a_out"},  a_out,  1'b0);
    chk({tag, "_a_last"}, a_last, 1'b0);
    chk({tag, "_a_busy"}, a_busy, 1'b0);
    chk({tag, "_a_rdy"},  a_rdy,  1'b1);
  endtask

  task automatic chk_idle_b(input string tag);
    chk({tag, "_b_vld"},  b_vld,  1'b0);
    chk({tag, "_b_out"},  b_out,  1'b0);
    chk({tag, "_b_last"}, b_last, 1'b0);
    chk({tag, "_b_busy"}, b_busy, 1'b0);
    chk({tag, "_b_rdy"},  b_rdy,  1'b1);
  endtask

  logic [3:0]  w4;
  logic [15:0] w16;
  logic [7:0]  w8;

  initial begin
    // reset state
    @(negedge clk);
    chk_idle_a("rst");
    chk_idle_b("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=4 MSB-first 1101 -> 1,1,0,1
    @(negedge clk);
    a_in_valid = 1; a_par = 4'b1101; a_lsb = 0;
    @(negedge clk);
    a_in_valid = 0;
    chk("msb_lat_vld", a_vld, 1'b0);
    chk("msb_held_rdy", a_rdy, 1'b0);
    w4 = 4'b1101;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      chk($sformatf("msb_bit%0d", i), a_out, w4[i]);
      chk($sformatf("msb_vld%0d", i), a_vld, 1'b1);
      chk($sformatf("msb_last%0d", i), a_last, i == 0);
    end
    @(negedge clk);
    chk_idle_a("msb_end");

    // WIDTH=4 LSB-first 1101 -> 1,0,1,1
    a_in_valid = 1; a_par = 4'b1101; a_lsb = 1;
    @(negedge clk);
    a_in_valid = 0; a_lsb = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("lsb_bit%0d", i), a_out, w4[i]);
      chk($sformatf("lsb_last%0d", i), a_last, i == 3);
    end
    @(negedge clk);
    chk_idle_a("lsb_end");

    // WIDTH=8 back-to-back A5, 3C
    b_in_valid = 1; b_par = 8'hA5;
    @(negedge clk);
    b_par = 8'h3C;
    w16 = 16'hA53C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 1) b_in_valid = 0;
      chk($sformatf("b2b_bit%0d", i), b_out, w16[15-i]);
      chk($sformatf("b2b_vld%0d", i), b_vld, 1'b1);
      chk($sformatf("b2b_last%0d", i), b_last,
          (i == 7) || (i == 15));
      if (i >= 1 && i <= 7)
        chk($sformatf("b2b_rdy%0d", i), b_rdy, 1'b0);
    end
    @(negedge clk);
    chk_idle_b("b2b_end");

    // WIDTH=8 F0 with shift_en low for 3 cycles at bit 2
    b_in_valid = 1; b_par = 8'hF0;
    @(negedge clk);
    b_in_valid = 0;
    w8 = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("frz_bit%0d", i), b_out, w8[7-i]);
      chk($sformatf("frz_last%0d", i), b_last, i == 7);
      if (i == 2) begin
        b_sen = 0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk($sformatf("frz_hold_out%0d", j), b_out, 1'b1);
          chk($sformatf("frz_hold_vld%0d", j), b_vld, 1'b1);
          chk($sformatf("frz_hold_last%0d", j), b_last, 1'b0);
        end
        b_sen = 1;
      end
    end
    @(negedge clk);
    chk_idle_b("frz_end");

    // reset mid-frame with a word held
    b_in_valid = 1; b_par = 8'h81;
    @(negedge clk);
    b_par = 8'h7E;
    @(negedge clk);
    chk("rstm_bit0", b_out, 1'b1);
    @(negedge clk);
    b_in_valid = 0;
    chk("rstm_held_rdy", b_rdy, 1'b0);
    chk("rstm_busy", b_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_b("rstm_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("rstm_after_vld%0d", i), b_vld, 1'b0);
      chk($sformatf("rstm_after_busy%0d", i), b_busy, 1'b0);
    end

    // WIDTH=4 word offered on the last-bit cycle
    a_in_valid = 1; a_par = 4'b1001; a_lsb = 0;
    @(negedge clk);
    a_in_valid = 0;
    w4 = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      chk($sformatf("gap_f1_bit%0d", i), a_out, w4[i]);
      if (i == 0) begin
        chk("gap_f1_last", a_last, 1'b1);
        chk("gap_f1_rdy", a_rdy, 1'b1);
        a_in_valid = 1; a_par = 4'b0110;
      end
    end
    @(negedge clk);
    a_in_valid = 0;
    chk("gap_vld", a_vld, 1'b0);
    chk("gap_rdy", a_rdy, 1'b0);
    chk("gap_busy", a_busy, 1'b1);
    w4 = 4'b0110;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      chk($sformatf("gap_f2_bit%0d", i), a_out, w4[i]);
      chk($sformatf("gap_f2_vld%0d", i), a_vld, 1'b1);
      chk($sformatf("gap_f2_last%0d", i), a_last, i == 0);
    end
    @(negedge clk);
    chk_idle_a("gap_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
